// File: rtl/sprite_dispatch_arbiter.sv
// sprite_dispatch_arbiter
//   Pops sprite descriptors from the sprite draw queue and hands each one to an
//   idle sprite_render channel. Channels are picked round-robin. Each channel
//   runs its own IDLE -> RUN -> RELEASE state machine. A frame flush aborts
//   every running channel.
//
//   Optional statistics counters are built only when SPRITE_DISPATCH_STATS_EN
//   is defined. Otherwise dispatch_count and stall_count are tied to zero.
//
// Ports
//   clock, reset             system clock, synchronous active-high reset
//   frame_flush              single-cycle pulse, aborts all channels
//   queue_is_empty           queue holds no descriptor
//   queue_sprite_*           head descriptor fields (id, x, y, scale)
//   queue_dequeue            one-cycle pop strobe to the queue
//   rend_en / rend_rst       per-channel renderer enable / reset
//   rend_id/x/y/scale        packed descriptor fields, channel k at [k*W +: W]
//   rend_finished            per-channel done level from the renderer
//   busy_mask                1 = channel in RUN
//   all_idle                 every channel IDLE and queue empty
//   dispatch_count           sprites dispatched (statistics build only)
//   stall_count              cycles the queue waited with no idle channel
module sprite_dispatch_arbiter #(
  parameter int NUM_RENDERERS = 4,
  parameter int ID_W          = 8,
  parameter int COORD_W       = 16,
  parameter int SCALE_W       = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               frame_flush,
  input  logic                               queue_is_empty,
  input  logic [ID_W-1:0]                    queue_sprite_id,
  input  logic [COORD_W-1:0]                 queue_sprite_x,
  input  logic [COORD_W-1:0]                 queue_sprite_y,
  input  logic [SCALE_W-1:0]                 queue_sprite_scale,
  output logic                               queue_dequeue,
  output logic [NUM_RENDERERS-1:0]           rend_en,
  output logic [NUM_RENDERERS-1:0]           rend_rst,
  output logic [NUM_RENDERERS*ID_W-1:0]      rend_id,
  output logic [NUM_RENDERERS*COORD_W-1:0]   rend_x,
  output logic [NUM_RENDERERS*COORD_W-1:0]   rend_y,
  output logic [NUM_RENDERERS*SCALE_W-1:0]   rend_scale,
  input  logic [NUM_RENDERERS-1:0]           rend_finished,
  output logic [NUM_RENDERERS-1:0]           busy_mask,
  output logic                               all_idle,
  output logic [15:0]                        dispatch_count,
  output logic [15:0]                        stall_count
);

  localparam int PTR_W  = (NUM_RENDERERS > 1) ? $clog2(NUM_RENDERERS) : 1;
  localparam int CAND_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } chan_state_t;

  chan_state_t              state     [NUM_RENDERERS];
  chan_state_t              state_nxt [NUM_RENDERERS];
  logic [NUM_RENDERERS-1:0] idle;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         rr_ptr_nxt;
  logic [CAND_W-1:0]        cand;
  logic                     found;
  logic                     grant;

  always_comb begin
    idle      = '0;
    busy_mask = '0;
    for (int k = 0; k < NUM_RENDERERS; k++) begin
      idle[k]      = (state[k] == ST_IDLE);
      busy_mask[k] = (state[k] == ST_RUN);
    end
  end

  assign all_idle = (&idle) && queue_is_empty;

  // Round-robin scan: first IDLE channel at or above rr_ptr, wrapping.
  // cand is one bit wider so rr_ptr + i never overflows before the wrap.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_RENDERERS; i++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(i);
      if (cand >= CAND_W'(NUM_RENDERERS)) cand = cand - CAND_W'(NUM_RENDERERS);
      if (!found && idle[cand[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  // The pop strobe of the previous grant blocks this cycle, so the queue head
  // is never consumed twice.
  assign grant      = found && !queue_is_empty && !queue_dequeue && !frame_flush;
  assign rr_ptr_nxt = (grant_idx == PTR_W'(NUM_RENDERERS - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Per-channel next state; flush outranks finished, and finished is only
  // looked at in RUN.
  always_comb begin
    for (int k = 0; k < NUM_RENDERERS; k++) begin
      state_nxt[k] = state[k];
      case (state[k])
        ST_IDLE:    if (grant && grant_idx == PTR_W'(k)) state_nxt[k] = ST_RUN;
        ST_RUN:     if (frame_flush || rend_finished[k]) state_nxt[k] = ST_RELEASE;
        ST_RELEASE: state_nxt[k] = ST_IDLE;
        default:    state_nxt[k] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_RENDERERS; k++) begin
      if (reset) state[k] <= ST_IDLE;
      else       state[k] <= state_nxt[k];
    end
  end

  // Registered outputs: decoded from next state so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr        <= '0;
      queue_dequeue <= 1'b0;
      rend_en       <= '0;
      rend_rst      <= '1;
      rend_id       <= '0;
      rend_x        <= '0;
      rend_y        <= '0;
      rend_scale    <= '0;
    end else begin
      queue_dequeue <= grant;
      if (grant) rr_ptr <= rr_ptr_nxt;
      for (int k = 0; k < NUM_RENDERERS; k++) begin
        rend_en[k]  <= (state_nxt[k] == ST_RUN);
        rend_rst[k] <= (state_nxt[k] != ST_RUN);
        if (grant && grant_idx == PTR_W'(k)) begin
          rend_id[k*ID_W +: ID_W]          <= queue_sprite_id;
          rend_x[k*COORD_W +: COORD_W]     <= queue_sprite_x;
          rend_y[k*COORD_W +: COORD_W]     <= queue_sprite_y;
          rend_scale[k*SCALE_W +: SCALE_W] <= queue_sprite_scale;
        end
      end
    end
  end

`ifdef SPRITE_DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall;
  assign stall = !queue_is_empty && !(|idle) && !frame_flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      dispatch_count <= '0;
      stall_count    <= '0;
    end else begin
      if (grant) dispatch_count <= sat_inc(dispatch_count);
      if (stall) stall_count    <= sat_inc(stall_count);
    end
  end
`else
  assign dispatch_count = '0;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_sprite_dispatch_arbiter.sv
// Directed testbench for sprite_dispatch_arbiter (4 channels, default widths).
// A small descriptor queue model drives the queue head and pops on
// queue_dequeue.
module tb_sprite_dispatch_arbiter;

  localparam int N = 4;

`ifdef SPRITE_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_flush;
  logic          queue_is_empty;
  logic [7:0]    queue_sprite_id;
  logic [15:0]   queue_sprite_x;
  logic [15:0]   queue_sprite_y;
  logic [7:0]    queue_sprite_scale;
  logic          queue_dequeue;
  logic [N-1:0]  rend_en;
  logic [N-1:0]  rend_rst;
  logic [N*8-1:0]  rend_id;
  logic [N*16-1:0] rend_x;
  logic [N*16-1:0] rend_y;
  logic [N*8-1:0]  rend_scale;
  logic [N-1:0]  rend_finished;
  logic [N-1:0]  busy_mask;
  logic          all_idle;
  logic [15:0]   dispatch_count;
  logic [15:0]   stall_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q_id [16];
  logic [15:0] q_x  [16];
  logic [15:0] q_y  [16];
  logic [7:0]  q_s  [16];
  int q_rd = 0;
  int q_wr = 0;

  sprite_dispatch_arbiter #(
    .NUM_RENDERERS(N), .ID_W(8), .COORD_W(16), .SCALE_W(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .frame_flush        (frame_flush),
    .queue_is_empty     (queue_is_empty),
    .queue_sprite_id    (queue_sprite_id),
    .queue_sprite_x     (queue_sprite_x),
    .queue_sprite_y     (queue_sprite_y),
    .queue_sprite_scale (queue_sprite_scale),
    .queue_dequeue      (queue_dequeue),
    .rend_en            (rend_en),
    .rend_rst           (rend_rst),
    .rend_id            (rend_id),
    .rend_x             (rend_x),
    .rend_y             (rend_y),
    .rend_scale         (rend_scale),
    .rend_finished      (rend_finished),
    .busy_mask          (busy_mask),
    .all_idle           (all_idle),
    .dispatch_count     (dispatch_count),
    .stall_count        (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_head();
    queue_is_empty = (q_rd == q_wr);
    if (q_rd != q_wr) begin
      queue_sprite_id    = q_id[q_rd];
      queue_sprite_x     = q_x[q_rd];
      queue_sprite_y     = q_y[q_rd];
      queue_sprite_scale = q_s[q_rd];
    end else begin
      queue_sprite_id    = '0;
      queue_sprite_x     = '0;
      queue_sprite_y     = '0;
      queue_sprite_scale = '0;
    end
  endtask

  task automatic push(input logic [7:0] id, input logic [15:0] x,
                      input logic [15:0] y, input logic [7:0] s);
    q_id[q_wr] = id;
    q_x[q_wr]  = x;
    q_y[q_wr]  = y;
    q_s[q_wr]  = s;
    q_wr++;
    set_head();
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (queue_dequeue && q_rd != q_wr) begin
      q_rd++;
      set_head();
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    frame_flush   = 1'b0;
    rend_finished = '0;
    q_rd = 0;
    q_wr = 0;
    set_head();
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_en",       rend_en, 4'b0000);
    chk("rst_rst",      rend_rst, 4'b1111);
    chk("rst_deq",      queue_dequeue, 1'b0);
    chk("rst_busy",     busy_mask, 4'b0000);
    chk("rst_id",       rend_id, 32'h0);
    chk("rst_all_idle", all_idle, 1'b1);
    chk("rst_dispatch", dispatch_count, 16'd0);
    reset = 1'b0;

    // Single descriptor goes to channel 0 one cycle later
    push(8'd5, 16'd100, 16'd40, 8'd2);
    tick();
    chk("t1_en",    rend_en, 4'b0001);
    chk("t1_rst",   rend_rst, 4'b1110);
    chk("t1_id",    rend_id[7:0], 8'd5);
    chk("t1_x",     rend_x[15:0], 16'd100);
    chk("t1_y",     rend_y[15:0], 16'd40);
    chk("t1_scale", rend_scale[7:0], 8'd2);
    chk("t1_deq",   queue_dequeue, 1'b1);
    tick();
    chk("t1_deq_pulse", queue_dequeue, 1'b0);
    chk("t1_all_idle",  all_idle, 1'b0);
    push(8'd6, 16'd1, 16'd2, 8'd3);
    tick();
    chk("t1_rr_next", rend_en, 4'b0011);
    chk("t1_id1",     rend_id[15:8], 8'd6);

    // Five descriptors: grants on cycles 1,3,5,7, fifth stays queued
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(10 + i), 16'(i), 16'(i), 8'(i));
    tick();
    chk("t2_c1", rend_en, 4'b0001);
    tick();
    chk("t2_c2", rend_en, 4'b0001);
    tick();
    chk("t2_c3", rend_en, 4'b0011);
    tick();
    tick();
    chk("t2_c5", rend_en, 4'b0111);
    tick();
    tick();
    chk("t2_c7",     rend_en, 4'b1111);
    chk("t2_ids",    rend_id, 32'h0D0C0B0A);
    chk("t2_stall7", stall_count, 16'd0);
    tick();
    tick();
    tick();
    chk("t2_queued",   queue_is_empty, 1'b0);
    chk("t2_deq_idle", queue_dequeue, 1'b0);
    chk("t2_stall10",  stall_count, STATS ? 16'd3 : 16'd0);
    chk("t2_disp",     dispatch_count, STATS ? 16'd4 : 16'd0);

    // Channel 2 finishes: one RELEASE cycle, not re-granted until IDLE
    rend_finished = 4'b0100;
    tick();
    rend_finished = '0;
    chk("t3_rel_en",  rend_en, 4'b1011);
    chk("t3_rel_rst", rend_rst, 4'b0100);
    chk("t3_rel_bsy", busy_mask, 4'b1011);
    tick();
    chk("t3_idle_en",  rend_en, 4'b1011);
    chk("t3_idle_deq", queue_dequeue, 1'b0);
    tick();
    chk("t3_regrant",  rend_en, 4'b1111);
    chk("t3_id2",      rend_id[23:16], 8'd14);
    chk("t3_deq",      queue_dequeue, 1'b1);

    // rr_ptr=3 with channels 0 and 3 idle: 3 first, then wrap to 0
    rend_finished = 4'b1001;
    tick();
    rend_finished = '0;
    chk("t4_rel", rend_en, 4'b0110);
    tick();
    push(8'd20, 16'd7, 16'd8, 8'd1);
    push(8'd21, 16'd9, 16'd10, 8'd1);
    tick();
    chk("t4_g3",  rend_en, 4'b1110);
    chk("t4_id3", rend_id[31:24], 8'd20);
    tick();
    tick();
    chk("t4_g0",  rend_en, 4'b1111);
    chk("t4_id0", rend_id[7:0], 8'd21);

    // Flush with all channels running and the queue non-empty
    push(8'd30, 16'd11, 16'd12, 8'd4);
    frame_flush = 1'b1;
    tick();
    frame_flush = 1'b0;
    chk("t5_en",   rend_en, 4'b0000);
    chk("t5_rst",  rend_rst, 4'b1111);
    chk("t5_deq",  queue_dequeue, 1'b0);
    chk("t5_busy", busy_mask, 4'b0000);
    tick();
    chk("t5_wait", rend_en, 4'b0000);
    tick();
    chk("t5_resume", rend_en, 4'b0010);
    chk("t5_id1",    rend_id[15:8], 8'd30);
    chk("t5_deq2",   queue_dequeue, 1'b1);
    tick();
    // Flush also blocks a grant while idle channels exist
    push(8'd31, 16'd13, 16'd14, 8'd5);
    frame_flush = 1'b1;
    tick();
    frame_flush = 1'b0;
    chk("t5_blk_en",  rend_en, 4'b0000);
    chk("t5_blk_deq", queue_dequeue, 1'b0);
    tick();
    chk("t5_g2",    rend_en, 4'b0100);
    chk("t5_id2",   rend_id[23:16], 8'd31);
    chk("t5_disp",  dispatch_count, STATS ? 16'd9 : 16'd0);
    chk("t5_stall", stall_count, STATS ? 16'd6 : 16'd0);

    // Reset with three channels running
    push(8'd40, 16'd1, 16'd1, 8'd1);
    push(8'd41, 16'd2, 16'd2, 8'd2);
    tick();
    tick();
    chk("t6_g3", rend_en, 4'b1100);
    tick();
    tick();
    chk("t6_run3", rend_en, 4'b1101);
    reset = 1'b1;
    tick();
    chk("t6_en",       rend_en, 4'b0000);
    chk("t6_rst",      rend_rst, 4'b1111);
    chk("t6_deq",      queue_dequeue, 1'b0);
    chk("t6_busy",     busy_mask, 4'b0000);
    chk("t6_id",       rend_id, 32'h0);
    chk("t6_x",        rend_x, 64'h0);
    chk("t6_all_idle", all_idle, 1'b1);
    chk("t6_disp",     dispatch_count, 16'd0);
    chk("t6_stall",    stall_count, 16'd0);
    push(8'd50, 16'd3, 16'd3, 8'd3);
    tick();
    chk("t6_all_idle_q", all_idle, 1'b0);
    chk("t6_no_grant",   rend_en, 4'b0000);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_dispatch_arbiter.md
Name: sprite_dispatch_arbiter

Overview:
- N-channel successor to the two-renderer sprite distributor. Pops sprite descriptors from the sprite draw queue and assigns each one to an idle sprite_render instance.
- Arbitration is round-robin; each channel runs an explicit per-channel FSM; a frame-flush input aborts all renderers.
- Sits inside the sprite driver, between the sprite queue and NUM_RENDERERS sprite_render instances.

Parameters:
- NUM_RENDERERS, 4, number of render channels (2..8).
- ID_W, 8, sprite id width.
- COORD_W, 16, x/y coordinate width.
- SCALE_W, 8, scale width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_flush  in  1  single-cycle pulse; aborts all channels (tie to fb_resetting edge).
- queue_is_empty  in  1  queue holds no descriptor.
- queue_sprite_id  in  ID_W  head descriptor id.
- queue_sprite_x  in  COORD_W  head x.
- queue_sprite_y  in  COORD_W  head y.
- queue_sprite_scale  in  SCALE_W  head scale.
- queue_dequeue  out  1  one-cycle pop strobe.
- rend_en  out  NUM_RENDERERS  per-channel enable.
- rend_rst  out  NUM_RENDERERS  per-channel renderer reset.
- rend_id  out  NUM_RENDERERS*ID_W  packed ids; channel k at [k*ID_W +: ID_W].
- rend_x  out  NUM_RENDERERS*COORD_W  packed x, same packing rule.
- rend_y  out  NUM_RENDERERS*COORD_W  packed y, same packing rule.
- rend_scale  out  NUM_RENDERERS*SCALE_W  packed scale, same packing rule.
- rend_finished  in  NUM_RENDERERS  per-channel done level from the renderer.
- busy_mask  out  NUM_RENDERERS  1 = channel in RUN.
- all_idle  out  1  every channel in IDLE and queue_is_empty.
- dispatch_count  out  16  sprites dispatched (optional feature).
- stall_count  out  16  cycles stalled with no idle channel (optional feature).

Behaviour:
- Reset values:
  - Every channel in IDLE: rend_en=0, rend_rst=all ones, packed field outputs all 0.
  - queue_dequeue=0, rr_ptr=0, counters=0, busy_mask=0.
  - all_idle follows queue_is_empty.
- Per-channel FSM, all outputs registered:
  - IDLE: en=0, rst=1. When granted: latch descriptor fields, en=1, rst=0 -> RUN.
  - RUN: en=1, rst=0. rend_finished=1 -> RELEASE.
  - RELEASE: en=0, rst=1 for exactly one cycle -> IDLE. A channel cannot be granted while in RELEASE.
- Grant condition: !queue_is_empty && !queue_dequeue && !frame_flush && at least one channel in IDLE.
  - At most one grant per cycle.
  - Granted channel = first IDLE channel scanning from rr_ptr upward, modulo NUM_RENDERERS.
  - On grant, rr_ptr <= (granted+1) mod NUM_RENDERERS.
- queue_dequeue is asserted on the edge after a grant decision and held for exactly 1 cycle. Back-to-back grants are therefore at least 2 cycles apart; the queue head is valid again after the dequeue cycle.
- Latency: queue non-empty with an idle channel -> rend_en high and fields valid 1 cycle later, together with queue_dequeue.
- rend_finished is ignored outside RUN.
- A channel that finishes in the same cycle another channel is granted: both transitions occur.
- frame_flush, taking precedence over grants and finished:
  - Next cycle: all RUN channels -> RELEASE, IDLE channels stay IDLE, no grant, queue_dequeue=0 (any pending pop already issued completes normally).
  - rr_ptr is not reset by flush.
- reset mid-operation: immediate return to reset values on the next edge. Already-latched descriptors are discarded and not re-queued.
- busy_mask[k] = (state_k == RUN).

Optional Feature:
- Macro: SPRITE_DISPATCH_STATS_EN.
- Defined:
  - dispatch_count increments once per grant.
  - stall_count increments each cycle where !queue_is_empty && no channel is IDLE && !frame_flush.
  - Both saturate at 16'hFFFF, are cleared by reset only, and are unaffected by flush.
- Undefined: both outputs are constant 0 and no counter logic is inferred.

Test Plan:
- Reset, then queue holds 1 descriptor (id=5, x=100, y=40, scale=2):
  - Next cycle: rend_en=4'b0001, rend_id[7:0]=5, queue_dequeue pulses 1 cycle.
  - rr_ptr becomes 1.
- Queue holds 5 descriptors, no finished:
  - Channels 0,1,2,3 granted on cycles 1,3,5,7.
  - The fifth descriptor stays queued; stall_count counts from cycle 8 onward.
- Channel 2 in RUN, rend_finished[2]=1 for 1 cycle:
  - rend_en[2]=0 and rend_rst[2]=1 for exactly 1 cycle, then IDLE.
  - Channel 2 is not re-granted during RELEASE, even with the queue non-empty.
- rr_ptr=3, channels 0 and 3 idle:
  - Next grant goes to 3, then to 0 (wrap-around).
- frame_flush while channels 0-3 are in RUN and the queue is non-empty:
  - All en=0 and rst=1 next cycle, no queue_dequeue that cycle.
  - Grants resume 2 cycles after the flush, starting at the preserved rr_ptr.
- Assert reset with 3 channels in RUN:
  - All outputs return to reset values on the next edge.
  - With the macro defined, dispatch_count reads 0.
